// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write (busy) scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy status to the read ports.
module regfile_mp #(
   parameter  int XLEN     = 32,
   parameter  int NREGS    = 32,
   parameter  int NRD      = 2,
   parameter  int NWR      = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   input  logic                alloc_en_i,
   input  logic [AW-1:0]       alloc_addr_i,
   output logic [NREGS-1:0]    busy_vec_o
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin : next_state
      logic [AW-1:0] wa;
      // NOTE: every target gets a default before the conditional updates, so no latches are inferred.
      regs_d = regs_q;
      busy_d = busy_q;
      wa     = '0;
      // NOTE: blocking assignments in ascending port order make the highest-index writer win.
      for (int j = 0; j < NWR; j++) begin
         wa = wr_addr_i[j*AW +: AW];
         if (wr_en_i[j]) begin
            regs_d[wa] = wr_data_i[j*XLEN +: XLEN];
            busy_d[wa] = 1'b0;
         end
      end
      // A new producer outranks a writeback landing in the same cycle.
      if (alloc_en_i) begin
         busy_d[alloc_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         regs_d[0] = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is flop-based and must clear on reset, so it cannot map onto a RAM macro.
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin : read_ports
      logic [AW-1:0] ra;
      rd_data_o = '0;
      rd_busy_o = '0;
      ra        = '0;
      for (int i = 0; i < NRD; i++) begin
         ra = rd_addr_i[i*AW +: AW];
         rd_data_o[i*XLEN +: XLEN] = regs_q[ra];
         rd_busy_o[i]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
         for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra)) begin
               rd_data_o[i*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
               rd_busy_o[i]              = alloc_en_i && (alloc_addr_i == ra);
            end
         end
`endif
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_data_o[i*XLEN +: XLEN] = '0;
            rd_busy_o[i]              = 1'b0;
         end
      end
   end

   assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one instance with ZERO_REG=1 and one with ZERO_REG=0 share stimulus.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = $clog2(NREGS);

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                alloc_en;
   logic [AW-1:0]       alloc_addr;

   logic [NRD*XLEN-1:0] rd_data_z, rd_data_n;
   logic [NRD-1:0]      rd_busy_z, rd_busy_n;
   logic [NREGS-1:0]    busy_vec_z, busy_vec_n;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_z), .rd_busy_o(rd_busy_z),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
      .alloc_addr_i(alloc_addr), .busy_vec_o(busy_vec_z));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
      .alloc_addr_i(alloc_addr), .busy_vec_o(busy_vec_n));

   always #5 clk = ~clk;

   // Reference model: index 0 mirrors dut_z, index 1 mirrors dut_n.
   logic [XLEN-1:0] m_reg  [2][NREGS];
   logic            m_busy [2][NREGS];

   typedef struct packed {
      logic [1:0][NRD*XLEN-1:0] data;
      logic [1:0][NRD-1:0]      busy;
      logic [1:0][NREGS-1:0]    vec;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   armed    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN:0] exp_read(input int k, input int a);
      logic [XLEN-1:0] d;
      logic            b;
      d = m_reg[k][a];
      b = m_busy[k][a];
`ifdef REGFILE_BYPASS_EN
      for (int j = NWR - 1; j >= 0; j--) begin
         if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
            d = wr_data[j*XLEN +: XLEN];
            b = alloc_en && int'(alloc_addr) == a;
            break;
         end
      end
`endif
      if (k == 0 && a == 0) begin
         d = '0;
         b = 1'b0;
      end
      return {b, d};
   endfunction

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
               m_reg[k][r]  = '0;
               m_busy[k][r] = 1'b0;
            end
         end else begin
            for (int r = 0; r < NREGS; r++) begin
               for (int j = NWR - 1; j >= 0; j--) begin
                  if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == r) begin
                     if (!(k == 0 && r == 0)) begin
                        m_reg[k][r]  = wr_data[j*XLEN +: XLEN];
                        m_busy[k][r] = 1'b0;
                     end
                     break;
                  end
               end
            end
            if (alloc_en && !(k == 0 && alloc_addr == '0)) m_busy[k][alloc_addr] = 1'b1;
         end
      end
   endtask

   // One clock cycle: predict this cycle's outputs, then advance the model across the edge.
   task automatic step();
      exp_t        e;
      logic [XLEN:0] r;
      e = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NRD; i++) begin
            r = exp_read(k, int'(rd_addr[i*AW +: AW]));
            e.data[k][i*XLEN +: XLEN] = r[XLEN-1:0];
            e.busy[k][i]              = r[XLEN];
         end
         for (int q = 0; q < NREGS; q++) e.vec[k][q] = m_busy[k][q];
      end
      if (armed) sb.push_back(e);
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("z1.rd_data",  64'(rd_data_z),  64'(e.data[0]));
         check("z1.rd_busy",  64'(rd_busy_z),  64'(e.busy[0]));
         check("z1.busy_vec", 64'(busy_vec_z), 64'(e.vec[0]));
         check("z0.rd_data",  64'(rd_data_n),  64'(e.data[1]));
         check("z0.rd_busy",  64'(rd_busy_n),  64'(e.busy[1]));
         check("z0.busy_vec", 64'(busy_vec_n), 64'(e.vec[1]));
      end
   end

   task automatic idle();
      rst      = 1'b0;
      wr_en    = '0;
      alloc_en = 1'b0;
   endtask

   task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
      wr_en[j]                = 1'b1;
      wr_addr[j*AW +: AW]     = AW'(a);
      wr_data[j*XLEN +: XLEN] = d;
   endtask

   task automatic rd(input int i, input int a);
      rd_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic al(input int a);
      alloc_en   = 1'b1;
      alloc_addr = AW'(a);
   endtask

   function automatic int rand_addr();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NREGS - 1));
   endfunction

   initial begin
      idle();
      rd_addr    = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_addr = '0;
      rst        = 1'b1;
      #1;
      step();
      step();
      armed = 1'b1;

      // Reset state, then reset clearing a written and an allocated register.
      idle(); rd(0, 5); rd(1, 7); step();
      wr(0, 5, 32'hDEADBEEF); al(7); step();
      idle(); step();
      rst = 1'b1; wr(1, 5, 32'h55); step();
      step();
      idle(); step();

      // Write visibility and same-cycle read.
      wr(0, 3, 32'h12345678); rd(1, 3); step();
      idle(); step();

      // Write-write conflict: higher port wins.
      wr(0, 9, 32'h1111); wr(1, 9, 32'h2222); rd(0, 9); step();
      idle(); step();

      // Alloc, busy window, then writeback clears it.
      rd(0, 4); al(4); step();
      idle(); step();
      step();
      wr(1, 4, 32'hAA); step();
      idle(); step();
      step();

      // Alloc and write of the same register in one cycle.
      al(4); wr(0, 4, 32'hBB); step();
      idle(); step();

      // Register 0 handling for both ZERO_REG settings.
      rd(0, 0); rd(1, 0); wr(0, 0, 32'hFFFFFFFF); al(0); step();
      idle(); step();

      // Reset while reg2 is busy and a write to reg2 is presented.
      al(2); rd(0, 2); step();
      idle(); rst = 1'b1; wr(0, 2, 32'h77); step();
      idle(); step();

      // Randomised traffic with address clustering and read/write collisions.
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         alloc_en = $urandom_range(0, 1) == 1;
         alloc_addr = AW'(rand_addr());
         for (int j = 0; j < NWR; j++) begin
            wr_en[j]                = $urandom_range(0, 1) == 1;
            wr_addr[j*AW +: AW]     = AW'(rand_addr());
            wr_data[j*XLEN +: XLEN] = $urandom;
         end
         for (int i = 0; i < NRD; i++) begin
            if ($urandom_range(0, 1) == 1)
               rd_addr[i*AW +: AW] = wr_addr[($urandom_range(0, NWR - 1))*AW +: AW];
            else
               rd_addr[i*AW +: AW] = AW'(rand_addr());
         end
         step();
      end

      idle();
      step();
      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
